// File: rtl/fasta_pkg.sv
// Shared types and defaults for the FASTA ROM arbiter: data widths, arbiter
// state encoding and requester port identifiers.
package fasta_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic PORT0 = 1'b0;   // fasta_to_sam_fsm converter
    localparam logic PORT1 = 1'b1;   // header/debug reader

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t own_state(input logic id);
        return (id == PORT1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line carrying (valid, requester id) alongside each ROM read so the
// returning byte can be routed back to the port that issued it.
module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic i_id,
    output logic o_valid,
    output logic o_id
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_id;

    // NOTE: clearing the valid bits on reset is what discards reads still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_id    <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/fasta_rom_arbiter.sv
// Round-robin, burst-locking arbiter sharing the single-port FASTA source ROM
// between the converter (port 0) and the header/debug reader (port 1).
module fasta_rom_arbiter
    import fasta_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ROM_LATENCY = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  last0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  last1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rom_ena,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    logic             r_gnt0, r_gnt1;
    logic             r_rr;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rvalid0, r_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

    logic [1:0] w_req;
    logic       w_owner, w_own_req, w_own_last, w_oth_req;
    logic       w_cnt_full, w_release, w_pick;
    logic       w_tag_valid, w_tag_id;

    assign w_req      = {req1, req0};
    assign w_owner    = r_gnt1;
    assign w_own_req  = w_req[w_owner];
    assign w_own_last = r_gnt1 ? last1 : last0;
    assign w_oth_req  = w_req[~w_owner];
    assign w_cnt_full = (r_burst_cnt == CNT_MAX);
    // A forced release only happens on a cycle that actually issued a read.
    assign w_release  = !w_own_req || w_own_last || (w_cnt_full && w_oth_req);
    assign w_pick     = w_req[~r_rr] ? ~r_rr : r_rr;

    assign rom_ena  = (r_gnt0 & req0) | (r_gnt1 & req1);
    assign rom_addr = r_gnt0 ? addr0 : (r_gnt1 ? addr1 : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rr        <= PORT1;   // last owner = port 1, so port 0 is favoured next
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_state <= own_state(w_pick);
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                    end
                end
                OWN0, OWN1: begin
                    if (w_release) begin
                        r_rr        <= w_owner;
                        r_burst_cnt <= '0;
                        if (w_oth_req) begin
                            r_state <= own_state(~w_owner);
                            r_gnt0  <= w_owner;
                            r_gnt1  <= ~w_owner;
                        end else begin
                            r_state <= IDLE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                        end
                    end else if (w_own_req && !w_cnt_full) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    rd_tag_pipe #(.DEPTH(ROM_LATENCY)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (rom_ena),
        .i_id    (r_gnt1),
        .o_valid (w_tag_valid),
        .o_id    (w_tag_id)
    );

    // The tag leaves the pipe in the same cycle the ROM presents the byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_tag_valid & ~w_tag_id;
            r_rvalid1 <= w_tag_valid & w_tag_id;
            if (w_tag_valid && !w_tag_id) r_rdata0 <= rom_data;
            if (w_tag_valid && w_tag_id)  r_rdata1 <= rom_data;
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_fasta_rom_arbiter.sv
// Bench for fasta_rom_arbiter: two instances (ROM latency 1 and 2) share the
// same requester stimulus and are checked against a transaction-level model.
module tb_fasta_rom_arbiter;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, last0, req1, last1;
    logic [15:0] addr0, addr1;

    logic        gnt0_w [2];
    logic        gnt1_w [2];
    logic        rv0_w  [2];
    logic        rv1_w  [2];
    logic        ena_w  [2];
    logic [7:0]  rd0_w  [2];
    logic [7:0]  rd1_w  [2];
    logic [7:0]  rom_d  [2];
    logic [15:0] raddr_w[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] q1, q2;
        always @(posedge clk) begin
            if (ena_w[g]) q1 <= raddr_w[g][7:0] ^ 8'h5A;
            q2 <= q1;
        end
        assign rom_d[g] = (g == 0) ? q1 : q2;

        fasta_rom_arbiter #(
            .ADDR_WIDTH(16), .DATA_WIDTH(8), .ROM_LATENCY(g + 1), .MAX_BURST(MAXB)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0), .addr0(addr0), .last0(last0),
            .gnt0(gnt0_w[g]), .rvalid0(rv0_w[g]), .rdata0(rd0_w[g]),
            .req1(req1), .addr1(addr1), .last1(last1),
            .gnt1(gnt1_w[g]), .rvalid1(rv1_w[g]), .rdata1(rd1_w[g]),
            .rom_ena(ena_w[g]), .rom_addr(raddr_w[g]), .rom_data(rom_d[g])
        );
    end

    typedef struct {
        int         due;
        int         dut;
        int         port;
        logic [7:0] data;
    } ret_t;

    ret_t        ret_q[$];
    int          n_cmp, n_bad, cyc;
    int          m_owner, m_rr, m_cnt;
    logic [7:0]  m_rdata [2][2];
    int          rem [2];
    logic [15:0] nxt [2];
    bit          use_last [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ret_q.delete();
        m_owner = -1;
        m_rr    = 1;
        m_cnt   = 0;
        cyc     = 0;
        for (int d = 0; d < 2; d++) begin
            m_rdata[d][0] = 8'h00;
            m_rdata[d][1] = 8'h00;
        end
        rem[0] = 0;
        rem[1] = 0;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_gnt0", tag, d), gnt0_w[d], 0);
            check($sformatf("%s_d%0d_gnt1", tag, d), gnt1_w[d], 0);
            check($sformatf("%s_d%0d_ena", tag, d), ena_w[d], 0);
            check($sformatf("%s_d%0d_addr", tag, d), raddr_w[d], 0);
            check($sformatf("%s_d%0d_rv0", tag, d), rv0_w[d], 0);
            check($sformatf("%s_d%0d_rv1", tag, d), rv1_w[d], 0);
            check($sformatf("%s_d%0d_rd0", tag, d), rd0_w[d], 0);
            check($sformatf("%s_d%0d_rd1", tag, d), rd1_w[d], 0);
        end
    endtask

    // One clock cycle: drive requesters, check outputs mid-cycle, advance model.
    task automatic cycle(input string tag);
        bit         rq [2];
        bit         lt [2];
        bit         ev [2][2];
        bit         exp_ena, rel;
        logic [15:0] exp_addr;
        ret_t       keep[$];
        int         x;
        for (int p = 0; p < 2; p++) begin
            rq[p] = (rem[p] > 0);
            lt[p] = use_last[p] && (rem[p] == 1);
        end
        req0 = rq[0]; addr0 = nxt[0]; last0 = lt[0];
        req1 = rq[1]; addr1 = nxt[1]; last1 = lt[1];
        @(negedge clk);

        exp_ena  = (m_owner >= 0) && rq[m_owner];
        exp_addr = (m_owner == 0) ? addr0 : (m_owner == 1) ? addr1 : 16'h0;
        for (int d = 0; d < 2; d++) begin
            ev[d][0] = 1'b0;
            ev[d][1] = 1'b0;
        end
        foreach (ret_q[i]) begin
            if (ret_q[i].due == cyc) begin
                ev[ret_q[i].dut][ret_q[i].port] = 1'b1;
                m_rdata[ret_q[i].dut][ret_q[i].port] = ret_q[i].data;
            end else begin
                keep.push_back(ret_q[i]);
            end
        end
        ret_q = keep;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_c%0d_d%0d_gnt0", tag, cyc, d), gnt0_w[d], m_owner == 0);
            check($sformatf("%s_c%0d_d%0d_gnt1", tag, cyc, d), gnt1_w[d], m_owner == 1);
            check($sformatf("%s_c%0d_d%0d_ena", tag, cyc, d), ena_w[d], exp_ena);
            check($sformatf("%s_c%0d_d%0d_addr", tag, cyc, d), raddr_w[d], exp_addr);
            check($sformatf("%s_c%0d_d%0d_rv0", tag, cyc, d), rv0_w[d], ev[d][0]);
            check($sformatf("%s_c%0d_d%0d_rv1", tag, cyc, d), rv1_w[d], ev[d][1]);
            check($sformatf("%s_c%0d_d%0d_rd0", tag, cyc, d), rd0_w[d], m_rdata[d][0]);
            check($sformatf("%s_c%0d_d%0d_rd1", tag, cyc, d), rd1_w[d], m_rdata[d][1]);
        end

        if (exp_ena) begin
            for (int d = 0; d < 2; d++)
                ret_q.push_back('{due: cyc + 2 + d, dut: d, port: m_owner,
                                  data: exp_addr[7:0] ^ 8'h5A});
            rem[m_owner]--;
            nxt[m_owner]++;
        end

        if (m_owner < 0) begin
            if (rq[1 - m_rr])  m_owner = 1 - m_rr;
            else if (rq[m_rr]) m_owner = m_rr;
        end else begin
            x   = m_owner;
            rel = !rq[x] || lt[x] || (m_cnt == MAXB - 1 && rq[1 - x]);
            if (rel) begin
                m_rr    = x;
                m_cnt   = 0;
                m_owner = rq[1 - x] ? 1 - x : -1;
            end else if (m_cnt < MAXB - 1) begin
                m_cnt++;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        while ((rem[0] > 0 || rem[1] > 0 || ret_q.size() > 0 || m_owner >= 0) && n < budget) begin
            cycle(tag);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic load(input int r0, input logic [15:0] a0, input bit l0,
                        input int r1, input logic [15:0] a1, input bit l1);
        rem[0] = r0; nxt[0] = a0; use_last[0] = l0;
        rem[1] = r1; nxt[1] = a1; use_last[1] = l1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req0 = 0; addr0 = '0; last0 = 0;
        req1 = 0; addr1 = '0; last1 = 0;
        use_last[0] = 0;
        use_last[1] = 0;
        nxt[0] = '0;
        nxt[1] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        // Port 0 alone: addresses 0..4, last on the fifth read.
        load(5, 16'h0000, 1, 0, 16'h0, 0);
        run("t2", 40);
        check("t2_gnt0_idle", gnt0_w[0], 0);
        check("t2_rd0_final", rd0_w[1], 8'h5E);

        // Simultaneous requests from idle: port 0 first, then port 1 without a bubble.
        load(3, 16'h0100, 1, 3, 16'h0200, 1);
        run("t3", 40);

        // Both stream 40 reads: forced handover every MAX_BURST reads.
        load(40, $urandom_range(0, 16'hFFFF), 1, 40, $urandom_range(0, 16'hFFFF), 1);
        run("t4", 200);

        // Owner drops req without last while reads are in flight.
        load(3, 16'h0300, 0, 2, 16'h0400, 1);
        run("t5a", 40);
        load(4, 16'hFFFE, 0, 0, 16'h0, 0);
        run("t5b", 40);

        // Reset asserted mid-burst: outputs clear at once, in-flight reads vanish.
        load(10, 16'h0500, 1, 0, 16'h0, 0);
        repeat (4) cycle("t1");
        rst_n = 1'b0;
        #1;
        check_zero("t1_async");
        repeat (3) begin
            @(negedge clk);
            check_zero("t1_hold");
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (4) cycle("t1_after");

        // Randomized request mixes.
        for (int r = 0; r < 12; r++) begin
            load($urandom_range(0, 24), 16'($urandom), 1'($urandom),
                 $urandom_range(0, 24), 16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) cycle("rnd_gap");
            run($sformatf("rnd%0d", r), 200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
